// File: rtl/neosd_cmd_ctrl.sv
// neosd_cmd_ctrl - SD CMD-line command/response sequencer.
//
// Transmits a 48-bit SD command frame {0,1,idx[5:0],arg[31:0],crc7,1}
// through an external 8-bit shift register (parallel load / serial shift,
// MSB shifted out first). The CRC7 is generated here. When a response is
// requested, it waits for a start bit on the CMD line, deserialises a 48-bit
// short response through the same register and checks its CRC7 and end bit.
//
// Ports
//   clk_i, rstn_i       clock, synchronous active-low reset
//   sd_bit_en_i         SD bit strobe, one CMD bit per high cycle
//   start_i             start a command (accepted only when idle)
//   cmd_idx_i/arg_i     command index / argument
//   resp_en_i           expect a 48-bit response (sampled with start_i)
//   busy_o, done_o      transaction in progress / one-cycle completion pulse
//   timeout_o           no response start bit within RESP_TIMEOUT strobes
//   crc_err_o           response CRC7 mismatch or end bit equal to 0
//   resp_idx_o/arg_o    response bits 45:40 / 39:8
//   sreg_*_o            shift-register control: enable, load, byte, serial in
//   sreg_pdata_i/sdata_i shift-register parallel output / serial output (bit 7)
//   cmd_i               CMD line input value
//   cmd_o, cmd_oe_o     CMD line output value / output enable
module neosd_cmd_ctrl #(
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned TO_W         = 7
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        sd_bit_en_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_idx_i,
  input  logic [31:0] cmd_arg_i,
  input  logic        resp_en_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        crc_err_o,
  output logic [5:0]  resp_idx_o,
  output logic [31:0] resp_arg_o,
  output logic        sreg_en_o,
  output logic        sreg_load_o,
  output logic [7:0]  sreg_pdata_o,
  output logic        sreg_sdata_o,
  input  logic [7:0]  sreg_pdata_i,
  input  logic        sreg_sdata_i,
  input  logic        cmd_i,
  output logic        cmd_o,
  output logic        cmd_oe_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [5:0]      idx_q;
  logic [31:0]     arg_q;
  logic            resp_en_q;
  logic [6:0]      crc_q;
  logic [5:0]      n_q;        // TX bit counter
  logic [5:0]      m_q;        // RX bit counter
  logic [TO_W-1:0] to_q;       // response timeout counter
  logic            byte_rdy_q;
  logic            err_q;      // sticky response error

  logic            tx_stb, tx_exit, wait_stb, rx_stb, rx_last;
  logic [6:0]      crc_tx, crc_rx;
  logic [TO_W-1:0] to_inc;
  logic            to_hit;
  logic [5:0]      m_inc;
  logic [2:0]      crc_sel;
  logic [2:0]      slot;
  logic [7:0]      tx_byte;

  // CRC7, polynomial x^7 + x^3 + 1, one bit per call
  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign tx_stb   = (state_q == S_TX)   && sd_bit_en_i && (n_q < 6'd48);
  assign tx_exit  = (state_q == S_TX)   && sd_bit_en_i && (n_q == 6'd48);
  assign wait_stb = (state_q == S_WAIT) && sd_bit_en_i;
  assign rx_stb   = (state_q == S_RX)   && sd_bit_en_i && (m_q < 6'd48);
  assign rx_last  = (state_q == S_RX)   && byte_rdy_q  && (m_q == 6'd48);

  // The bit on the line during TX is the one just shifted out (bit n-1)
  assign crc_tx  = crc7_next(crc_q, sreg_sdata_i);
  assign crc_rx  = crc7_next(crc_q, cmd_i);
  assign to_inc  = to_q + TO_W'(1);
  assign to_hit  = (to_inc == TO_W'(RESP_TIMEOUT));
  assign m_inc   = m_q + 6'd1;
  // m = 40..46 checks CRC bits 6..0
  assign crc_sel = 3'd6 - m_q[2:0];
  // byte_rdy follows the strobe that made m a multiple of 8
  assign slot    = m_q[5:3] - 3'd1;

  // Frame byte loaded at strobe n (n%8==0); the CRC byte needs the
  // combinational next value so that bit 39 is already included.
  always_comb begin
    tx_byte = '0;
    case (n_q[5:3])
      3'd0:    tx_byte = {2'b01, idx_q};
      3'd1:    tx_byte = arg_q[31:24];
      3'd2:    tx_byte = arg_q[23:16];
      3'd3:    tx_byte = arg_q[15:8];
      3'd4:    tx_byte = arg_q[7:0];
      3'd5:    tx_byte = {crc_tx, 1'b1};
      default: tx_byte = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    sreg_en_o    = 1'b0;
    sreg_load_o  = 1'b0;
    sreg_pdata_o = '0;
    cmd_o        = 1'b1;
    cmd_oe_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_TX;
      end
      S_TX: begin
        cmd_oe_o = 1'b1;
        cmd_o    = sreg_sdata_i;
        if (tx_stb) begin
          sreg_en_o = 1'b1;
          if (n_q[2:0] == 3'd0) begin
            sreg_load_o  = 1'b1;
            sreg_pdata_o = tx_byte;
          end
        end
        if (tx_exit) state_d = resp_en_q ? S_WAIT : S_FIN;
      end
      S_WAIT: begin
        if (wait_stb) begin
          if (!cmd_i) begin
            sreg_en_o = 1'b1;
            state_d   = S_RX;
          end else if (to_hit) begin
            state_d = S_FIN;
          end
        end
      end
      S_RX: begin
        if (rx_stb)  sreg_en_o = 1'b1;
        if (rx_last) state_d   = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_FIN);
  assign sreg_sdata_o = cmd_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      idx_q      <= '0;
      arg_q      <= '0;
      resp_en_q  <= 1'b0;
      crc_q      <= '0;
      n_q        <= '0;
      m_q        <= '0;
      to_q       <= '0;
      byte_rdy_q <= 1'b0;
      err_q      <= 1'b0;
      timeout_o  <= 1'b0;
      crc_err_o  <= 1'b0;
      resp_idx_o <= '0;
      resp_arg_o <= '0;
    end else begin
      byte_rdy_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            idx_q      <= cmd_idx_i;
            arg_q      <= cmd_arg_i;
            resp_en_q  <= resp_en_i;
            crc_q      <= '0;
            n_q        <= '0;
            m_q        <= '0;
            to_q       <= '0;
            err_q      <= 1'b0;
            timeout_o  <= 1'b0;
            crc_err_o  <= 1'b0;
            resp_idx_o <= '0;
            resp_arg_o <= '0;
          end
        end
        S_TX: begin
          if (tx_stb) begin
            n_q <= n_q + 6'd1;
            if ((n_q != 6'd0) && (n_q <= 6'd40)) crc_q <= crc_tx;
          end
          if (tx_exit) to_q <= '0;
        end
        S_WAIT: begin
          if (wait_stb) begin
            if (!cmd_i) begin
              // start bit: CRC restarts and absorbs the 0 just received
              m_q   <= 6'd1;
              crc_q <= crc7_next(7'd0, 1'b0);
            end else begin
              to_q <= to_inc;
              if (to_hit) timeout_o <= 1'b1;
            end
          end
        end
        S_RX: begin
          if (rx_stb) begin
            m_q        <= m_inc;
            byte_rdy_q <= (m_inc[2:0] == 3'd0);
            if (m_q <= 6'd39) begin
              crc_q <= crc_rx;
            end else if (m_q <= 6'd46) begin
              if (cmd_i != crc_q[crc_sel]) err_q <= 1'b1;
            end else if (!cmd_i) begin
              err_q <= 1'b1;
            end
          end
          // Capture reads the register value left by the previous strobe,
          // so a strobe in this same cycle does not disturb it.
          if (byte_rdy_q) begin
            case (slot)
              3'd0:    resp_idx_o         <= sreg_pdata_i[5:0];
              3'd1:    resp_arg_o[31:24]  <= sreg_pdata_i;
              3'd2:    resp_arg_o[23:16]  <= sreg_pdata_i;
              3'd3:    resp_arg_o[15:8]   <= sreg_pdata_i;
              3'd4:    resp_arg_o[7:0]    <= sreg_pdata_i;
              default: ;
            endcase
            if (m_q == 6'd48) crc_err_o <= err_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neosd_cmd_ctrl.sv
module tb_neosd_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        sd_bit_en_i;
  logic        start_i;
  logic [5:0]  cmd_idx_i;
  logic [31:0] cmd_arg_i;
  logic        resp_en_i;
  logic        busy_o, done_o, timeout_o, crc_err_o;
  logic [5:0]  resp_idx_o;
  logic [31:0] resp_arg_o;
  logic        sreg_en_o, sreg_load_o, sreg_sdata_o;
  logic [7:0]  sreg_pdata_o;
  logic [7:0]  sreg_pdata_i;
  logic        sreg_sdata_i;
  logic        cmd_i;
  logic        cmd_o, cmd_oe_o;

  always #5 clk = ~clk;

  // External CMD shift register
  logic [7:0] sr = '0;
  always @(posedge clk)
    if (sreg_en_o) sr <= sreg_load_o ? sreg_pdata_o : {sr[6:0], sreg_sdata_o};
  assign sreg_pdata_i = sr;
  assign sreg_sdata_i = sr[7];

  neosd_cmd_ctrl #(.RESP_TIMEOUT(64), .TO_W(7)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .sd_bit_en_i(sd_bit_en_i), .start_i(start_i),
    .cmd_idx_i(cmd_idx_i), .cmd_arg_i(cmd_arg_i), .resp_en_i(resp_en_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .crc_err_o(crc_err_o),
    .resp_idx_o(resp_idx_o), .resp_arg_o(resp_arg_o),
    .sreg_en_o(sreg_en_o), .sreg_load_o(sreg_load_o), .sreg_pdata_o(sreg_pdata_o),
    .sreg_sdata_o(sreg_sdata_o), .sreg_pdata_i(sreg_pdata_i), .sreg_sdata_i(sreg_sdata_i),
    .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe_o(cmd_oe_o)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        ren;
    int unsigned gap;    // 0 = random strobes
    int unsigned idle;   // WAIT strobes with cmd_i=1 before the start bit
    logic [47:0] resp;
    logic [47:0] exp_tx;
    logic        exp_to;
    logic        exp_ce;
    logic [5:0]  exp_idx;
    logic [31:0] exp_arg;
  } vec_t;

  typedef struct {
    logic [47:0] tx;
    int unsigned oe_strobes;
    int unsigned done_cnt;
    logic        busy1;
    logic        post_ok;
    logic        hung;
    logic        early_to;
    int          last_s;
    logic        to;
    logic        ce;
    logic [5:0]  ridx;
    logic [31:0] rarg;
  } res_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // CRC7 as the remainder of d * x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic vec_t model(input logic [5:0] idx, input logic [31:0] arg,
                                 input logic ren, input int unsigned gap,
                                 input int unsigned idle, input logic [47:0] resp);
    vec_t v;
    v.idx = idx; v.arg = arg; v.ren = ren; v.gap = gap; v.idle = idle; v.resp = resp;
    v.exp_tx = {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
    v.exp_to = 1'b0; v.exp_ce = 1'b0; v.exp_idx = '0; v.exp_arg = '0;
    if (ren) begin
      if (idle >= 64) v.exp_to = 1'b1;
      else begin
        v.exp_ce  = (resp[7:1] != crc7_ref(resp[47:8])) || !resp[0];
        v.exp_idx = resp[45:40];
        v.exp_arg = resp[39:8];
      end
    end
    return v;
  endfunction

  task automatic run_xact(input vec_t v, input int poke_at, output res_t r);
    int unsigned s, w;
    bit stb, done, poked;
    r.tx = '0; r.oe_strobes = 0; r.done_cnt = 0; r.busy1 = 0; r.post_ok = 1;
    r.hung = 0; r.early_to = 0; r.last_s = -1;
    @(posedge clk); #1;
    start_i = 1'b1; cmd_idx_i = v.idx; cmd_arg_i = v.arg; resp_en_i = v.ren;
    sd_bit_en_i = 1'b0; cmd_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; cmd_idx_i = ~v.idx; cmd_arg_i = ~v.arg; resp_en_i = ~v.ren;
    s = 0; done = 0; poked = 0;
    for (int k = 1; k <= 3000 && !done; k++) begin
      stb = (v.gap == 0) ? ($urandom_range(0, 1) == 1) : (((k - 1) % v.gap) == 0);
      sd_bit_en_i = stb;
      cmd_i = 1'b1;
      if (stb && s >= 49) begin
        w = s - 49;
        if (w >= v.idle && (w - v.idle) < 48) cmd_i = v.resp[47 - (w - v.idle)];
      end
      start_i = 1'b0;
      if (!poked && poke_at >= 0 && int'(s) == poke_at) begin
        poked = 1; start_i = 1'b1;
        cmd_idx_i = 6'($urandom); cmd_arg_i = $urandom; resp_en_i = 1'($urandom);
      end
      @(negedge clk);
      if (k == 1) r.busy1 = busy_o;
      if (stb) begin
        if (cmd_oe_o) r.oe_strobes++;
        if (s >= 1 && s <= 48) r.tx[48 - s] = cmd_o;
      end
      if (done_o) begin
        r.done_cnt++; r.last_s = int'(s) - 1; done = 1;
      end else if (timeout_o) r.early_to = 1;
      if (stb) s++;
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    r.hung = !done;
    for (int k = 0; k < 3; k++) begin
      sd_bit_en_i = 1'($urandom); cmd_i = 1'($urandom);
      @(negedge clk);
      if (done_o || busy_o || sreg_en_o) r.post_ok = 0;
      @(posedge clk); #1;
    end
    r.to = timeout_o; r.ce = crc_err_o; r.ridx = resp_idx_o; r.rarg = resp_arg_o;
    sd_bit_en_i = 1'b0; cmd_i = 1'b1;
  endtask

  task automatic check_xact(input string nm, input vec_t v, input res_t r);
    chk({nm, ".tx_frame"}, 64'(r.tx), 64'(v.exp_tx));
    chk({nm, ".oe_strobes"}, 64'(r.oe_strobes), 64'd49);
    chk({nm, ".done_cnt"}, 64'(r.done_cnt), 64'd1);
    chk({nm, ".busy_after_start"}, 64'(r.busy1), 64'd1);
    chk({nm, ".idle_after_done"}, 64'(r.post_ok), 64'd1);
    chk({nm, ".no_hang"}, 64'(r.hung), 64'd0);
    chk({nm, ".timeout"}, 64'(r.to), 64'(v.exp_to));
    chk({nm, ".crc_err"}, 64'(r.ce), 64'(v.exp_ce));
    chk({nm, ".resp_idx"}, 64'(r.ridx), 64'(v.exp_idx));
    chk({nm, ".resp_arg"}, 64'(r.rarg), 64'(v.exp_arg));
    if (v.exp_to) begin
      chk({nm, ".timeout_strobe"}, 64'(r.last_s), 64'd112);
      chk({nm, ".timeout_early"}, 64'(r.early_to), 64'd0);
    end
  endtask

  vec_t tab [9];
  vec_t v;
  res_t r;

  initial begin
    rstn_i = 1'b0; sd_bit_en_i = 1'b0; start_i = 1'b0; cmd_idx_i = '0;
    cmd_arg_i = '0; resp_en_i = 1'b0; cmd_i = 1'b1;

    //          idx    arg            ren  gap idle resp               exp_tx             to    ce    idx    arg
    tab[0] = '{6'd0,  32'h0,         1'b0, 4, 0,    48'h0,             48'h400000000095, 1'b0, 1'b0, 6'd0, 32'h0};
    tab[1] = '{6'd17, 32'h0,         1'b0, 1, 0,    48'h0,             48'h510000000055, 1'b0, 1'b0, 6'd0, 32'h0};
    tab[2] = '{6'd8,  32'h000001AA,  1'b0, 1, 0,    48'h0,             48'h48000001AA87, 1'b0, 1'b0, 6'd0, 32'h0};
    tab[3] = '{6'd8,  32'h000001AA,  1'b1, 2, 5,    48'h48000001AA87,  48'h48000001AA87, 1'b0, 1'b0, 6'd8, 32'h1AA};
    tab[4] = '{6'd8,  32'h000001AA,  1'b1, 1, 5,    48'h48000001AA85,  48'h48000001AA87, 1'b0, 1'b1, 6'd8, 32'h1AA};
    tab[5] = '{6'd8,  32'h000001AA,  1'b1, 3, 5,    48'h48000001AA86,  48'h48000001AA87, 1'b0, 1'b1, 6'd8, 32'h1AA};
    tab[6] = '{6'd8,  32'h000001AA,  1'b1, 3, 1000, 48'h48000001AA87,  48'h48000001AA87, 1'b1, 1'b0, 6'd0, 32'h0};
    tab[7] = '{6'd8,  32'h000001AA,  1'b1, 1, 63,   48'h48000001AA87,  48'h48000001AA87, 1'b0, 1'b0, 6'd8, 32'h1AA};
    tab[8] = '{6'd8,  32'h000001AA,  1'b1, 2, 64,   48'h48000001AA87,  48'h48000001AA87, 1'b1, 1'b0, 6'd0, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        64'({busy_o, done_o, timeout_o, crc_err_o, sreg_en_o, sreg_load_o, cmd_oe_o, cmd_o,
             resp_idx_o, resp_arg_o, sreg_pdata_o}),
        64'({7'b0, 1'b1, 6'd0, 32'd0, 8'd0}));
    @(posedge clk); #1;
    rstn_i = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_xact(tab[i], (i == 3) ? 10 : -1, r);
      check_xact($sformatf("vec%0d", i), tab[i], r);
    end

    // Reset in the middle of TX, after 20 strobes
    @(posedge clk); #1;
    start_i = 1'b1; cmd_idx_i = 6'd17; cmd_arg_i = 32'h12345678; resp_en_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sd_bit_en_i = 1'b1;
      @(posedge clk); #1;
    end
    sd_bit_en_i = 1'b0;
    @(negedge clk);
    chk("midtx.oe_before_reset", 64'(cmd_oe_o), 64'd1);
    @(posedge clk); #1;
    rstn_i = 1'b0;
    @(posedge clk); #1;
    rstn_i = 1'b1;
    @(negedge clk);
    chk("midtx.after_reset", 64'({cmd_oe_o, busy_o, done_o, cmd_o}), 64'b0001);
    run_xact(tab[0], -1, r);
    check_xact("post_reset_cmd0", tab[0], r);

    // Randomised transactions against the reference model
    for (int i = 0; i < 20; i++) begin
      logic [39:0] body;
      logic [47:0] resp;
      int unsigned fb;
      body = {1'b0, 1'($urandom), 6'($urandom), 32'($urandom)};
      resp = {body, crc7_ref(body), 1'b1};
      if ($urandom_range(0, 2) == 0) begin
        fb = $urandom_range(0, 46);
        resp[fb] = ~resp[fb];
      end
      v = model(6'($urandom), $urandom, 1'($urandom_range(0, 3) != 0),
                $urandom_range(0, 3), $urandom_range(0, 70), resp);
      run_xact(v, int'($urandom_range(0, 130)), r);
      check_xact($sformatf("rand%0d", i), v, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
